// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if: operand/result bundle for the ripple-carry adder/subtractor.
//
// Signals:
//   in_valid  operands valid this cycle (a, b, sub_en sampled when high)
//   a, b      WIDTH-bit operands
//   sub_en    0 = a + b, 1 = a - b
//   result    registered sum/difference, modulo 2^WIDTH
//   cout      registered carry out of the MSB (for subtraction: 1 = no borrow)
//   overflow  registered signed overflow
//   zero      registered, high when result == 0
//   out_valid one-cycle pulse when result/flags update
//
// Modports:
//   master  issues operands and observes results (e.g. the execute stage)
//   slave   the adder itself
interface ripple_carry_adder_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_en;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, a, b, sub_en,
        input  result, cout, overflow, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, sub_en,
        output result, cout, overflow, zero, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: two's-complement adder/subtractor built from a chain of WIDTH
// single-bit full adders, with registered result and flags (one cycle of latency).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low; clears all outputs, overrides in_valid
//   bus    ripple_carry_adder_if.slave: in_valid/a/b/sub_en in,
//          result/cout/overflow/zero/out_valid out
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    ripple_carry_adder_if.slave bus
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_msb_in;
    logic             carry_out;

    // Subtraction is a + ~b + 1: invert b and feed sub_en in as the LSB carry.
    assign b_eff = bus.b ^ {WIDTH{bus.sub_en}};

    // Each stage owns its carry signals so the chain is a plain net-to-net ripple
    // rather than a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_lsb
            assign c_in = bus.sub_en;
        end else begin : g_chain
            assign c_in = g_fa[i-1].c_out;
        end

        assign sum[i] = bus.a[i] ^ b_eff[i] ^ c_in;
        assign c_out  = (bus.a[i] & b_eff[i]) | (c_in & (bus.a[i] ^ b_eff[i]));
    end

    assign carry_msb_in = g_fa[WIDTH-1].c_in;
    assign carry_out    = g_fa[WIDTH-1].c_out;

    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    always_comb begin
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        valid_d    = 1'b0;
        if (bus.in_valid) begin
            result_d   = sum;
            cout_d     = carry_out;
            // Signed overflow: carry into the sign bit differs from carry out of it.
            overflow_d = carry_out ^ carry_msb_in;
            zero_d     = (sum == '0);
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: drives a 32-bit and an 8-bit adder side by side with the same
// (truncated) operands and compares every registered output against an arithmetic model.
module tb_ripple_carry_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(32)) bus32 ();
    ripple_carry_adder_if #(.WIDTH(8))  bus8 ();

    ripple_carry_adder #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    ripple_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Expected registered state per DUT: index 0 = 32-bit, index 1 = 8-bit.
    longint unsigned exp_res [2];
    bit              exp_co  [2];
    bit              exp_ov  [2];
    bit              exp_z   [2];
    bit              exp_vld;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings.
    function automatic void model(input int w, input longint unsigned a_in,
                                  input longint unsigned b_in, input bit sub,
                                  output longint unsigned res, output bit co,
                                  output bit ov, output bit z);
        longint unsigned modulus = 64'd1 << w;
        longint unsigned a = a_in % modulus;
        longint unsigned b = b_in % modulus;
        longint          half = longint'(modulus / 2);
        longint          sa, sb, st;
        if (sub) begin
            res = (a + modulus - b) % modulus;
            co  = (a >= b);
        end else begin
            res = (a + b) % modulus;
            co  = ((a + b) >= modulus);
        end
        sa = (longint'(a) >= half) ? longint'(a) - longint'(modulus) : longint'(a);
        sb = (longint'(b) >= half) ? longint'(b) - longint'(modulus) : longint'(b);
        st = sub ? sa - sb : sa + sb;
        ov = (st < -half) || (st >= half);
        z  = (res == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".res32"}, 64'(bus32.result),    exp_res[0]);
        check({tag, ".co32"},  64'(bus32.cout),      64'(exp_co[0]));
        check({tag, ".ov32"},  64'(bus32.overflow),  64'(exp_ov[0]));
        check({tag, ".z32"},   64'(bus32.zero),      64'(exp_z[0]));
        check({tag, ".vld32"}, 64'(bus32.out_valid), 64'(exp_vld));
        check({tag, ".res8"},  64'(bus8.result),     exp_res[1]);
        check({tag, ".co8"},   64'(bus8.cout),       64'(exp_co[1]));
        check({tag, ".ov8"},   64'(bus8.overflow),   64'(exp_ov[1]));
        check({tag, ".z8"},    64'(bus8.zero),       64'(exp_z[1]));
        check({tag, ".vld8"},  64'(bus8.out_valid),  64'(exp_vld));
    endtask

    task automatic clear_expect();
        for (int d = 0; d < 2; d++) begin
            exp_res[d] = 0;
            exp_co[d]  = 1'b0;
            exp_ov[d]  = 1'b0;
            exp_z[d]   = 1'b0;
        end
        exp_vld = 1'b0;
    endtask

    task automatic drive(input logic valid, input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
        bus32.in_valid = valid;
        bus32.a        = a;
        bus32.b        = b;
        bus32.sub_en   = sub;
        bus8.in_valid  = valid;
        bus8.a         = a[7:0];
        bus8.b         = b[7:0];
        bus8.sub_en    = sub;
    endtask

    // One accepted operation on both DUTs, checked after the following edge.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input bit sub);
        drive(1'b1, a, b, sub);
        model(32, 64'(a), 64'(b), sub, exp_res[0], exp_co[0], exp_ov[0], exp_z[0]);
        model(8,  64'(a), 64'(b), sub, exp_res[1], exp_co[1], exp_ov[1], exp_z[1]);
        exp_vld = 1'b1;
        tick();
        check_outputs(tag);
    endtask

    // Idle cycle with junk operands: state holds, out_valid drops.
    task automatic idle(input string tag);
        drive(1'b0, $urandom, $urandom, 1'($urandom));
        exp_vld = 1'b0;
        tick();
        check_outputs(tag);
    endtask

    initial begin
        clear_expect();
        rst_n = 1'b0;
        drive(1'b1, 32'd5, 32'd7, 1'b0);

        // Reset overrides in_valid.
        tick();
        check_outputs("rst0");
        tick();
        check_outputs("rst1");
        rst_n = 1'b1;

        // Directed arithmetic, issued back to back.
        op("add_5_7",     32'd5,        32'd7,        1'b0);
        op("add_wrap",    32'hFFFFFFFF, 32'd1,        1'b0);
        op("sub_5_7",     32'd5,        32'd7,        1'b1);
        op("sub_7_5",     32'd7,        32'd5,        1'b1);
        op("sub_9_9",     32'd9,        32'd9,        1'b1);
        op("add_ovf",     32'h7FFFFFFF, 32'd1,        1'b0);
        op("sub_ovf",     32'h80000000, 32'd1,        1'b1);
        op("add_80_80",   32'h00000080, 32'h00000080, 1'b0);
        op("sub_80_80",   32'h00000080, 32'h00000080, 1'b1);
        op("add_ff_ff",   32'h000000FF, 32'h000000FF, 1'b0);
        op("sub_ff_ff",   32'h000000FF, 32'h000000FF, 1'b1);
        op("sub_0_80",    32'h00000000, 32'h00000080, 1'b1);

        // Throughput burst then hold.
        op("burst0", 32'd100,      32'd23,       1'b0);
        op("burst1", 32'd100,      32'd123,      1'b1);
        op("burst2", 32'h12345678, 32'h87654321, 1'b0);
        idle("hold0");
        idle("hold1");

        // Reset mid-stream discards the in-flight operation.
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        rst_n = 1'b0;
        clear_expect();
        tick();
        check_outputs("rst_mid");
        rst_n = 1'b1;
        idle("post_rst");

        // Randomised with occasional bubbles.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle("rnd_idle");
            end else begin
                op("rnd", $urandom, $urandom, 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
